// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: load-use stalls, branch squashes,
// data-memory freezes with a timeout watchdog, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             use_rs1_de,
    input  logic             use_rs2_de,
    input  logic [4:0]       rd_ex,
    input  logic             RUWr_ex,
    input  logic             DMRd_ex,
    input  logic             br_taken_ex,
    input  logic             mem_req_me,
    input  logic             mem_ack,
    input  logic             clr_cnt,
    output logic             stall_fe,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             stall_me,
    output logic             flush_de,
    output logic             flush_ex,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           freeze;
    logic           load_use;

    // Freeze outranks everything: while memory is stalled, a branch or load-use
    // seen now will simply be presented again once the pipe moves.
    always_comb begin
        freeze   = 1'b0;
        load_use = 1'b0;
        stall_fe = 1'b0;
        stall_de = 1'b0;
        stall_ex = 1'b0;
        stall_me = 1'b0;
        flush_de = 1'b0;
        flush_ex = 1'b0;

        case (state)
            RUN:      freeze = mem_req_me && !mem_ack;
            MEM_WAIT: freeze = !mem_ack;
            default:  freeze = 1'b1;
        endcase

        load_use = DMRd_ex && RUWr_ex && (rd_ex != 5'd0) &&
                   ((use_rs1_de && (rs1_de == rd_ex)) ||
                    (use_rs2_de && (rs2_de == rd_ex)));

        if (freeze) begin
            stall_fe = 1'b1;
            stall_de = 1'b1;
            stall_ex = 1'b1;
            stall_me = 1'b1;
        end else if (br_taken_ex) begin
            flush_de = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_fe = 1'b1;
            stall_de = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // wait_cnt counts frozen cycles of the current access; reaching
    // MEM_TIMEOUT-1 while still unacknowledged makes the freeze exactly MEM_TIMEOUT long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req_me && !mem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                        state   <= ERROR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ERROR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_fe && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_de && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl, checked against a cycle-level
// behavioural model of frozen-cycle counting and hazard priorities.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_de, rs2_de, rd_ex;
    logic             use_rs1_de, use_rs2_de, RUWr_ex, DMRd_ex;
    logic             br_taken_ex, mem_req_me, mem_ack, clr_cnt;
    logic             stall_fe, stall_de, stall_ex, stall_me;
    logic             flush_de, flush_ex, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .use_rs1_de(use_rs1_de), .use_rs2_de(use_rs2_de),
        .rd_ex(rd_ex), .RUWr_ex(RUWr_ex), .DMRd_ex(DMRd_ex),
        .br_taken_ex(br_taken_ex), .mem_req_me(mem_req_me), .mem_ack(mem_ack),
        .clr_cnt(clr_cnt),
        .stall_fe(stall_fe), .stall_de(stall_de), .stall_ex(stall_ex), .stall_me(stall_me),
        .flush_de(flush_de), .flush_ex(flush_ex), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ruwr;
        logic       dmrd;
        logic       br;
        logic       mreq;
        logic       mack;
        logic       clr;
    } stim_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: length of the ongoing frozen stretch, error flag, counter values
    int m_frozen = 0;
    bit m_err    = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_frozen = 0;
        m_err    = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic applyStimulus(input stim_t s);
        bit frz, lu, e_sfe, e_fde, e_fex;
        rs1_de      = s.rs1;
        rs2_de      = s.rs2;
        use_rs1_de  = s.u1;
        use_rs2_de  = s.u2;
        rd_ex       = s.rd;
        RUWr_ex     = s.ruwr;
        DMRd_ex     = s.dmrd;
        br_taken_ex = s.br;
        mem_req_me  = s.mreq;
        mem_ack     = s.mack;
        clr_cnt     = s.clr;
        @(negedge clk);

        frz   = m_err || (((m_frozen > 0) || s.mreq) && !s.mack);
        lu    = s.dmrd && s.ruwr && (s.rd != 0) &&
                ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
        e_sfe = frz || (!s.br && lu);
        e_fde = !frz && s.br;
        e_fex = !frz && (s.br || lu);

        checkOutput("stall_fe", 32'(stall_fe), 32'(e_sfe));
        checkOutput("stall_de", 32'(stall_de), 32'(e_sfe));
        checkOutput("stall_ex", 32'(stall_ex), 32'(frz));
        checkOutput("stall_me", 32'(stall_me), 32'(frz));
        checkOutput("flush_de", 32'(flush_de), 32'(e_fde));
        checkOutput("flush_ex", 32'(flush_ex), 32'(e_fex));
        checkOutput("mem_err", 32'(mem_err), 32'(m_err));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        checkOutput("flush_cnt", 32'(flush_cnt), 32'(m_flush));

        if (!m_err) begin
            if (frz) begin
                m_frozen++;
                if (m_frozen == MEM_TIMEOUT) m_err = 1'b1;
            end else begin
                m_frozen = 0;
            end
        end
        if (s.clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_sfe && m_stall < CNT_MAX) m_stall++;
            if (e_fde && m_flush < CNT_MAX) m_flush++;
        end

        @(posedge clk);
        #1;
    endtask

    function automatic stim_t loadUse(input logic [4:0] rd);
        stim_t s = '0;
        s.dmrd = 1'b1;
        s.ruwr = 1'b1;
        s.rd   = rd;
        s.rs2  = rd;
        s.u2   = 1'b1;
        return s;
    endfunction

    function automatic stim_t memStim(input bit ack);
        stim_t s = '0;
        s.mreq = 1'b1;
        s.mack = ack;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rs1  = 5'($urandom_range(0, 3));
        s.rs2  = 5'($urandom_range(0, 3));
        s.u1   = 1'($urandom_range(0, 1));
        s.u2   = 1'($urandom_range(0, 1));
        s.rd   = 5'($urandom_range(0, 3));
        s.ruwr = 1'($urandom_range(0, 1));
        s.dmrd = 1'($urandom_range(0, 1));
        s.br   = ($urandom_range(0, 7) == 0);
        s.mreq = ($urandom_range(0, 3) == 0);
        s.mack = 1'($urandom_range(0, 1));
        s.clr  = ($urandom_range(0, 29) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        rst         = 1'b1;
        rs1_de      = '0;
        rs2_de      = '0;
        rd_ex       = '0;
        use_rs1_de  = 1'b0;
        use_rs2_de  = 1'b0;
        RUWr_ex     = 1'b0;
        DMRd_ex     = 1'b0;
        br_taken_ex = 1'b0;
        mem_req_me  = 1'b0;
        mem_ack     = 1'b0;
        clr_cnt     = 1'b0;
        #12;
        checkOutput("rst_stall_fe", 32'(stall_fe), 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use stalls one cycle; rd=0 never stalls
        applyStimulus(loadUse(5'd5));
        applyStimulus('0);
        checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        applyStimulus(loadUse(5'd0));
        checkOutput("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch outranks load-use
        s    = loadUse(5'd7);
        s.br = 1'b1;
        applyStimulus(s);
        checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // Three-cycle memory wait then ack
        for (int i = 0; i < 3; i++) applyStimulus(memStim(1'b0));
        applyStimulus(memStim(1'b1));
        checkOutput("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        checkOutput("mw_mem_err", 32'(mem_err), 32'd0);

        // Branch and load-use during a freeze are ignored
        applyStimulus(memStim(1'b0));
        for (int i = 0; i < 2; i++) begin
            s      = loadUse(5'd3);
            s.br   = 1'b1;
            s.mreq = 1'b1;
            applyStimulus(s);
        end
        applyStimulus(memStim(1'b1));

        // Clear wins over a simultaneous stall
        s     = loadUse(5'd9);
        s.clr = 1'b1;
        applyStimulus(s);
        checkOutput("clr_stall_cnt", 32'(stall_cnt), 32'd0);

        // Saturation of both counters
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) applyStimulus(memStim(1'b0));
            applyStimulus(memStim(1'b1));
        end
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        s    = '0;
        s.br = 1'b1;
        for (int i = 0; i < CNT_MAX + 3; i++) applyStimulus(s);
        checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 2000; i++) applyStimulus(randStim());

        // Timeout into ERROR, late ack ignored, then asynchronous reset
        applyStimulus('0);
        rst = 1'b1;
        #1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(memStim(1'b0));
        checkOutput("to_mem_err", 32'(mem_err), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(memStim(1'b1));
        checkOutput("to_late_ack_err", 32'(mem_err), 32'd1);
        applyStimulus('0);
        checkOutput("to_held_stall", 32'(stall_me), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("arst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("arst_stall_fe", 32'(stall_fe), 32'd0);
        checkOutput("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("arst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) applyStimulus(randStim());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage (FE/DE/EX/ME/WB) RISC-V core; it sits beside the forwarding unit.
- Resolves the hazards forwarding cannot:
  - load-use: stall plus bubble;
  - taken branch/jump in EX: squash;
  - data-memory wait: freeze the whole pipe.
- Supervises memory waits with a timeout FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive frozen cycles tolerated for one memory access before error (>=2)
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rs1_de  input  5  rs1 of instruction in DE
rs2_de  input  5  rs2 of instruction in DE
use_rs1_de  input  1  DE instruction reads rs1
use_rs2_de  input  1  DE instruction reads rs2
rd_ex  input  5  destination register of instruction in EX
RUWr_ex  input  1  EX instruction writes register file
DMRd_ex  input  1  EX instruction is a load
br_taken_ex  input  1  branch/jump in EX redirects PC this cycle
mem_req_me  input  1  ME instruction is accessing data memory
mem_ack  input  1  data memory completes access this cycle
clr_cnt  input  1  synchronous clear of both performance counters
stall_fe  output  1  hold PC
stall_de  output  1  hold FE/DE register
stall_ex  output  1  hold DE/EX register
stall_me  output  1  hold EX/ME register
flush_de  output  1  zero FE/DE register (NOP)
flush_ex  output  1  zero DE/EX register (NOP)
mem_err  output  1  sticky memory-timeout error
stall_cnt  output  CNT_W  cycles with stall_fe=1
flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
Reset and outputs:
- Reset is asynchronous and active-high.
- Reset clears: state=RUN, wait_cnt=0, both counters=0, mem_err=0.
- Control outputs are combinational (Mealy) from state and inputs, so they act in the same cycle.
- With no inputs asserted, all control outputs are 0.

FSM states: RUN, MEM_WAIT, ERROR.

Freeze condition, evaluated first:
- freeze = (state=RUN & mem_req_me & !mem_ack) | (state=MEM_WAIT & !mem_ack) | state=ERROR.
- freeze -> stall_fe/de/ex/me=1, flush_de=flush_ex=0; branch and load-use logic is ignored that cycle.

RUN transitions:
- mem_req_me & !mem_ack -> MEM_WAIT, wait_cnt=1.
- Otherwise stay in RUN.
- mem_req_me & mem_ack in the same cycle -> no freeze, stay in RUN.

MEM_WAIT transitions:
- mem_ack -> RUN, wait_cnt=0; freeze drops that same cycle.
- !mem_ack & wait_cnt=MEM_TIMEOUT-1 -> ERROR. The total freeze is therefore exactly MEM_TIMEOUT cycles.
- Otherwise wait_cnt+1.

ERROR:
- mem_err=1.
- Permanent freeze; leaves only on rst.
- mem_ack is ignored.

Taken branch (not frozen):
- br_taken_ex -> flush_de=1, flush_ex=1, no stalls.
- Takes priority over load-use, because the DE instruction is wrong-path.

Load-use (not frozen, no branch):
- Condition: DMRd_ex & RUWr_ex & rd_ex!=0 & ((use_rs1_de & rs1_de=rd_ex) | (use_rs2_de & rs2_de=rd_ex)).
- Response: stall_fe=1, stall_de=1, flush_ex=1 for exactly one cycle.
- The condition clears naturally on the next cycle once the load moves to ME.
- rd_ex=0 never causes a hazard.

Counters:
- stall_cnt increments on each cycle with stall_fe=1.
- flush_cnt increments on each branch flush cycle.
- Both saturate at 2^CNT_W-1 with no wrap.
- clr_cnt has priority over increment; a cleared counter reads 0 on the next cycle.

Reset mid-operation:
- An asserted rst in any state forces the reset values immediately, without waiting for a clock edge.
- When rst deasserts, operation resumes in RUN.

Test Plan:
- Load-use: DMRd_ex=1, RUWr_ex=1, rd_ex=5, rs2_de=5, use_rs2_de=1 for one cycle -> stall_fe=stall_de=flush_ex=1 that cycle only; stall_cnt=1. Repeat with rd_ex=0 -> no stall.
- Branch vs load-use: br_taken_ex=1 together with a load-use match -> flush_de=flush_ex=1, stall_fe=0; flush_cnt increments by 1, stall_cnt unchanged.
- Memory wait: mem_req_me=1, mem_ack low for 3 cycles then high -> all four stalls high for 3 cycles and low on the ack cycle; state back to RUN; stall_cnt=3; mem_err=0.
- Timeout: MEM_TIMEOUT=16, mem_ack never asserted -> 16 frozen cycles, then mem_err=1 with stalls still held. A late mem_ack has no effect. rst then clears mem_err, stalls and counters asynchronously.
- Freeze priority: during MEM_WAIT, assert br_taken_ex and a load-use match -> flushes stay 0 and stalls stay 1 until mem_ack.
- Counters: preload to 2^CNT_W-1 via a long stall (use CNT_W=4) -> stall_cnt holds at 15. clr_cnt together with a stall cycle -> counter reads 0 next cycle.
